// File: rtl/red_pitaya_sys_bus_mux_if.sv
// ---------------------------------------------------------------------------
// red_pitaya_sys_bus_mux_if
//
// Bundles the signals of a single-master to multi-slave system bus.
// The interconnect sits between one bus master (the CPU) and NS register
// slaves.
//
//   m_*_i  : request from the CPU (address, write data, byte select, strobes)
//   m_*_o  : response to the CPU (read data, error, acknowledge)
//   s_*_o  : request fanned out to the slaves (shared addr/data/sel, one-hot
//            per-slave strobes)
//   s_*_i  : per-slave responses (read data packed 32 bits per slave)
//
// Modports:
//   master : view of the interconnect, which masters the slave ports and
//            answers the CPU.
//   slave  : view of the surroundings (CPU plus slaves) that drive the
//            interconnect's inputs and observe its outputs.
// ---------------------------------------------------------------------------
interface red_pitaya_sys_bus_mux_if #(
   parameter int NS = 8
);
   logic [31:0]      m_addr_i;
   logic [31:0]      m_wdata_i;
   logic [3:0]       m_sel_i;
   logic             m_wen_i;
   logic             m_ren_i;
   logic [31:0]      m_rdata_o;
   logic             m_err_o;
   logic             m_ack_o;

   logic [31:0]      s_addr_o;
   logic [31:0]      s_wdata_o;
   logic [3:0]       s_sel_o;
   logic [NS-1:0]    s_wen_o;
   logic [NS-1:0]    s_ren_o;
   logic [NS*32-1:0] s_rdata_i;
   logic [NS-1:0]    s_err_i;
   logic [NS-1:0]    s_ack_i;

   modport master (
      input  m_addr_i, m_wdata_i, m_sel_i, m_wen_i, m_ren_i,
      input  s_rdata_i, s_err_i, s_ack_i,
      output m_rdata_o, m_err_o, m_ack_o,
      output s_addr_o, s_wdata_o, s_sel_o, s_wen_o, s_ren_o
   );

   modport slave (
      output m_addr_i, m_wdata_i, m_sel_i, m_wen_i, m_ren_i,
      output s_rdata_i, s_err_i, s_ack_i,
      input  m_rdata_o, m_err_o, m_ack_o,
      input  s_addr_o, s_wdata_o, s_sel_o, s_wen_o, s_ren_o
   );
endinterface

// File: rtl/red_pitaya_sys_bus_mux.sv
// ---------------------------------------------------------------------------
// red_pitaya_sys_bus_mux
//
// Single-master to multi-slave system bus interconnect. Each CPU strobe is
// decoded by address bits [22:20] to one slave, which receives a one-cycle
// registered strobe. The selected slave's read data / error / ack are
// returned to the CPU one cycle after its ack. A timeout counter answers
// with an error when the slave never acknowledges, and addresses that
// select a nonexistent slave are answered with an error immediately.
//
// Parameters:
//   NS  : number of slave ports (1..8)
//   TMO : acknowledge timeout in cycles (1..65535)
// Ports:
//   clk_i : system clock
//   rst_i : synchronous reset, active-high
//   bus   : bus bundle (master modport), see red_pitaya_sys_bus_mux_if
// ---------------------------------------------------------------------------
module red_pitaya_sys_bus_mux #(
   parameter int NS  = 8,
   parameter int TMO = 255
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   red_pitaya_sys_bus_mux_if.master        bus
);

   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_reg, state_next;
   logic [2:0]    idx_reg, idx_next;
   logic [15:0]   cnt_reg, cnt_next;
   logic [31:0]   s_addr_reg, s_addr_next;
   logic [31:0]   s_wdata_reg, s_wdata_next;
   logic [3:0]    s_sel_reg, s_sel_next;
   logic [NS-1:0] s_wen_reg, s_wen_next;
   logic [NS-1:0] s_ren_reg, s_ren_next;
   logic [31:0]   m_rdata_reg, m_rdata_next;
   logic          m_err_reg, m_err_next;
   logic          m_ack_reg, m_ack_next;

   logic          req;
   logic [2:0]    req_idx;
   logic [NS-1:0] req_hit;   // one-hot decode of the incoming address
   logic [NS-1:0] cur_hit;   // one-hot decode of the captured index
   logic          sel_ack;
   logic          sel_err;
   logic [31:0]   sel_rdata;

   assign req     = bus.m_wen_i | bus.m_ren_i;
   assign req_idx = bus.m_addr_i[22:20];

   // Index values >= NS decode to no hit at all, so an all-zero req_hit
   // doubles as the "no such slave" indication.
   generate
      for (genvar gi = 0; gi < NS; gi++) begin : g_decode
         assign req_hit[gi] = (req_idx == 3'(gi));
         assign cur_hit[gi] = (idx_reg == 3'(gi));
      end
   endgenerate

   // Only the slave that was strobed may complete the transaction.
   always_comb begin
      sel_ack   = |(bus.s_ack_i & cur_hit);
      sel_err   = |(bus.s_err_i & cur_hit);
      sel_rdata = '0;
      for (int k = 0; k < NS; k++) begin
         if (cur_hit[k]) begin
            sel_rdata = bus.s_rdata_i[32*k +: 32];
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      cnt_next     = cnt_reg;
      s_addr_next  = s_addr_reg;
      s_wdata_next = s_wdata_reg;
      s_sel_next   = s_sel_reg;
      s_wen_next   = '0;
      s_ren_next   = '0;
      m_rdata_next = m_rdata_reg;
      m_err_next   = 1'b0;
      m_ack_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (req) begin
               s_addr_next  = bus.m_addr_i;
               s_wdata_next = bus.m_wdata_i;
               s_sel_next   = bus.m_sel_i;
               idx_next     = req_idx;
               if (|req_hit) begin
                  // A simultaneous read and write is treated as a write.
                  s_wen_next = req_hit & {NS{bus.m_wen_i}};
                  s_ren_next = req_hit & {NS{bus.m_ren_i & ~bus.m_wen_i}};
                  cnt_next   = '0;
                  state_next = BUSY;
               end else begin
                  m_ack_next   = 1'b1;
                  m_err_next   = 1'b1;
                  m_rdata_next = '0;
               end
            end
         end
         BUSY: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (sel_ack) begin
               m_ack_next   = 1'b1;
               m_err_next   = sel_err;
               m_rdata_next = sel_rdata;
               state_next   = IDLE;
            end else if (cnt_reg == TMO_LAST) begin
               m_ack_next   = 1'b1;
               m_err_next   = 1'b1;
               m_rdata_next = '0;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         cnt_reg     <= '0;
         s_addr_reg  <= '0;
         s_wdata_reg <= '0;
         s_sel_reg   <= '0;
         s_wen_reg   <= '0;
         s_ren_reg   <= '0;
         m_rdata_reg <= '0;
         m_err_reg   <= 1'b0;
         m_ack_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         cnt_reg     <= cnt_next;
         s_addr_reg  <= s_addr_next;
         s_wdata_reg <= s_wdata_next;
         s_sel_reg   <= s_sel_next;
         s_wen_reg   <= s_wen_next;
         s_ren_reg   <= s_ren_next;
         m_rdata_reg <= m_rdata_next;
         m_err_reg   <= m_err_next;
         m_ack_reg   <= m_ack_next;
      end
   end

   assign bus.s_addr_o  = s_addr_reg;
   assign bus.s_wdata_o = s_wdata_reg;
   assign bus.s_sel_o   = s_sel_reg;
   assign bus.s_wen_o   = s_wen_reg;
   assign bus.s_ren_o   = s_ren_reg;
   assign bus.m_rdata_o = m_rdata_reg;
   assign bus.m_err_o   = m_err_reg;
   assign bus.m_ack_o   = m_ack_reg;

endmodule

// File: tb/tb_red_pitaya_sys_bus_mux.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_sys_bus_mux
//
// Directed bench for red_pitaya_sys_bus_mux with NS=6, TMO=255. The bench
// plays both the CPU and the slaves. Inputs are changed 1 time unit after
// a rising edge and outputs are sampled at the same point, so "cycle n"
// means the interval after the n-th step() since the master strobe.
// ---------------------------------------------------------------------------
module tb_red_pitaya_sys_bus_mux;

   localparam int NS  = 6;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   red_pitaya_sys_bus_mux_if #(.NS(NS)) bus ();

   red_pitaya_sys_bus_mux #(.NS(NS), .TMO(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic master_idle();
      bus.m_wen_i = 1'b0;
      bus.m_ren_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step(); step();
      n_checks++; if (bus.m_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_ack got %b want 0", bus.m_ack_o); end
      n_checks++; if (bus.m_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_err got %b want 0", bus.m_err_o); end
      n_checks++; if (bus.m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_m_rdata got %h want 0", bus.m_rdata_o); end
      n_checks++; if ({bus.s_wen_o, bus.s_ren_o} !== 12'h0) begin n_fail++; $display("FAIL reset_s_strobes got %h want 0", {bus.s_wen_o, bus.s_ren_o}); end
      n_checks++; if ({bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o} !== 68'h0) begin n_fail++; $display("FAIL reset_s_bus got %h want 0", {bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o}); end
      rst = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_write_idx0();
      bus.m_addr_i = 32'h4000_0030; bus.m_wdata_i = 32'hFE; bus.m_sel_i = 4'hF; bus.m_wen_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if (bus.s_wen_o !== 6'h01) begin n_fail++; $display("FAIL wr_s_wen got %h want 01", bus.s_wen_o); end
      n_checks++; if (bus.s_ren_o !== 6'h00) begin n_fail++; $display("FAIL wr_s_ren got %h want 00", bus.s_ren_o); end
      n_checks++; if (bus.s_wdata_o !== 32'hFE) begin n_fail++; $display("FAIL wr_s_wdata got %h want fe", bus.s_wdata_o); end
      n_checks++; if (bus.s_addr_o !== 32'h4000_0030) begin n_fail++; $display("FAIL wr_s_addr got %h want 40000030", bus.s_addr_o); end
      n_checks++; if (bus.s_sel_o !== 4'hF) begin n_fail++; $display("FAIL wr_s_sel got %h want f", bus.s_sel_o); end
      step();                                                  // cycle 2
      n_checks++; if (bus.s_wen_o !== 6'h00) begin n_fail++; $display("FAIL wr_strobe_width got %h want 00", bus.s_wen_o); end
      bus.s_ack_i = 6'h01;
      step(); bus.s_ack_i = 6'h00;                             // cycle 3
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b10) begin n_fail++; $display("FAIL wr_resp ack/err got %b want 10", {bus.m_ack_o, bus.m_err_o}); end
      step();                                                  // cycle 4
      n_checks++; if (bus.m_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width got %b want 0", bus.m_ack_o); end
      $display("test_write_idx0 done");
   endtask

   task automatic test_read_idx3();
      bus.s_rdata_i[127:96] = 32'h1234_5678;
      bus.s_rdata_i[63:32]  = 32'hDEAD_BEEF;
      bus.s_err_i = 6'h02;
      bus.m_addr_i = 32'h4030_0008; bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if (bus.s_ren_o !== 6'h08) begin n_fail++; $display("FAIL rd_s_ren got %h want 08", bus.s_ren_o); end
      n_checks++; if (bus.s_wen_o !== 6'h00) begin n_fail++; $display("FAIL rd_s_wen got %h want 00", bus.s_wen_o); end
      bus.s_ack_i = 6'h02;                                     // foreign ack only
      step();                                                  // cycle 2
      n_checks++; if (bus.m_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_foreign_ack got %b want 0", bus.m_ack_o); end
      bus.s_ack_i = 6'h0A;
      step(); bus.s_ack_i = 6'h00;                             // cycle 3
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b10) begin n_fail++; $display("FAIL rd_resp ack/err got %b want 10", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata got %h want 12345678", bus.m_rdata_o); end
      bus.s_err_i = 6'h00;
      step();
      $display("test_read_idx3 done");
   endtask

   task automatic test_decode_error();
      bus.m_addr_i = 32'h4070_0000; bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b11) begin n_fail++; $display("FAIL dec7_resp ack/err got %b want 11", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL dec7_rdata got %h want 0", bus.m_rdata_o); end
      n_checks++; if ({bus.s_wen_o, bus.s_ren_o} !== 12'h0) begin n_fail++; $display("FAIL dec7_strobes got %h want 0", {bus.s_wen_o, bus.s_ren_o}); end
      bus.m_addr_i = 32'h4060_0000; bus.m_wen_i = 1'b1;        // idx == NS
      step(); master_idle();
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b11) begin n_fail++; $display("FAIL dec6_resp ack/err got %b want 11", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if ({bus.s_wen_o, bus.s_ren_o} !== 12'h0) begin n_fail++; $display("FAIL dec6_strobes got %h want 0", {bus.s_wen_o, bus.s_ren_o}); end
      step();
      n_checks++; if (bus.m_ack_o !== 1'b0) begin n_fail++; $display("FAIL dec_ack_width got %b want 0", bus.m_ack_o); end
      $display("test_decode_error done");
   endtask

   task automatic test_timeout();
      int early;
      bus.s_rdata_i[95:64] = 32'hCAFE_F00D;
      bus.s_err_i = 6'h00;
      // Run 1: slave 2 never acks.
      bus.m_addr_i = 32'h4020_0010; bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if (bus.s_ren_o !== 6'h04) begin n_fail++; $display("FAIL tmo_s_ren got %h want 04", bus.s_ren_o); end
      early = 0;
      for (int c = 2; c <= 255; c++) begin
         step();
         if (bus.m_ack_o !== 1'b0) early++;
      end
      n_checks++; if (early !== 0) begin n_fail++; $display("FAIL tmo_early_ack got %0d want 0", early); end
      step();                                                  // cycle 256
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b11) begin n_fail++; $display("FAIL tmo_resp ack/err got %b want 11", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata got %h want 0", bus.m_rdata_o); end
      // Run 2: ack arrives in the last accepted cycle.
      bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      early = 0;
      for (int c = 2; c <= 255; c++) begin
         step();
         if (bus.m_ack_o !== 1'b0) early++;
      end
      n_checks++; if (early !== 0) begin n_fail++; $display("FAIL tmo2_early_ack got %0d want 0", early); end
      bus.s_ack_i = 6'h04;                                     // cycle 255
      step(); bus.s_ack_i = 6'h00;                             // cycle 256
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b10) begin n_fail++; $display("FAIL tmo2_resp ack/err got %b want 10", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tmo2_rdata got %h want cafef00d", bus.m_rdata_o); end
      step();
      n_checks++; if ({bus.m_ack_o, bus.m_rdata_o} !== {1'b0, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL tmo2_hold got %h want 0cafef00d", {bus.m_ack_o, bus.m_rdata_o}); end
      $display("test_timeout done");
   endtask

   task automatic test_err_concurrent_drop();
      int acks;
      bus.s_rdata_i[63:32] = 32'h0BAD_BEEF;
      bus.s_err_i = 6'h02;
      bus.m_addr_i = 32'h4010_0004; bus.m_wdata_i = 32'h55;
      bus.m_wen_i = 1'b1; bus.m_ren_i = 1'b1;
      acks = 0;
      step(); master_idle();                                   // cycle 1
      acks += int'(bus.m_ack_o);
      n_checks++; if ({bus.s_wen_o, bus.s_ren_o} !== {6'h02, 6'h00}) begin n_fail++; $display("FAIL cc_strobes wen/ren got %h want 080", {bus.s_wen_o, bus.s_ren_o}); end
      step();                                                  // cycle 2
      acks += int'(bus.m_ack_o);
      bus.m_addr_i = 32'h4000_0000; bus.m_ren_i = 1'b1;        // dropped
      step(); master_idle();                                   // cycle 3
      acks += int'(bus.m_ack_o);
      n_checks++; if (bus.s_ren_o !== 6'h00) begin n_fail++; $display("FAIL drop_s_ren got %h want 00", bus.s_ren_o); end
      n_checks++; if (bus.s_addr_o !== 32'h4010_0004) begin n_fail++; $display("FAIL drop_s_addr got %h want 40100004", bus.s_addr_o); end
      bus.s_ack_i = 6'h02;
      step(); bus.s_ack_i = 6'h00;                             // cycle 4
      acks += int'(bus.m_ack_o);
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b11) begin n_fail++; $display("FAIL errpass_resp ack/err got %b want 11", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL errpass_rdata got %h want 0badbeef", bus.m_rdata_o); end
      for (int c = 5; c <= 10; c++) begin
         step();
         acks += int'(bus.m_ack_o);
      end
      n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL drop_ack_count got %0d want 1", acks); end
      bus.s_err_i = 6'h00;
      $display("test_err_concurrent_drop done");
   endtask

   task automatic test_reset_mid();
      bus.m_addr_i = 32'h4000_0040; bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if (bus.s_ren_o !== 6'h01) begin n_fail++; $display("FAIL rst_mid_s_ren got %h want 01", bus.s_ren_o); end
      step();                                                  // cycle 2
      rst = 1'b1;
      step(); rst = 1'b0;                                      // cycle 3
      n_checks++; if ({bus.m_ack_o, bus.m_err_o, bus.m_rdata_o} !== 34'h0) begin n_fail++; $display("FAIL rst_mid_m_out got %h want 0", {bus.m_ack_o, bus.m_err_o, bus.m_rdata_o}); end
      n_checks++; if ({bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o, bus.s_wen_o, bus.s_ren_o} !== 80'h0) begin n_fail++; $display("FAIL rst_mid_s_out got %h want 0", {bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o, bus.s_wen_o, bus.s_ren_o}); end
      bus.s_ack_i = 6'h01;                                     // stale ack
      step(); bus.s_ack_i = 6'h00;                             // cycle 4
      n_checks++; if (bus.m_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale_ack got %b want 0", bus.m_ack_o); end
      // Follow-up write to idx 3, acked in the strobe cycle.
      bus.m_addr_i = 32'h4030_0000; bus.m_wdata_i = 32'h77; bus.m_wen_i = 1'b1;
      step(); master_idle();                                   // cycle 1
      n_checks++; if ({bus.s_wen_o, bus.s_wdata_o} !== {6'h08, 32'h77}) begin n_fail++; $display("FAIL rst_next_strobe got %h want 0800000077", {bus.s_wen_o, bus.s_wdata_o}); end
      bus.s_ack_i = 6'h08;
      step(); bus.s_ack_i = 6'h00;                             // cycle 2
      n_checks++; if ({bus.m_ack_o, bus.m_err_o} !== 2'b10) begin n_fail++; $display("FAIL rst_next_resp ack/err got %b want 10", {bus.m_ack_o, bus.m_err_o}); end
      n_checks++; if (bus.m_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_next_rdata got %h want 12345678", bus.m_rdata_o); end
      step();
      $display("test_reset_mid done");
   endtask

   task automatic test_back_to_back();
      bus.s_rdata_i[127:96] = 32'hA5A5_5A5A;
      bus.m_addr_i = 32'h4000_0050; bus.m_wdata_i = 32'h11; bus.m_wen_i = 1'b1;
      step(); master_idle();                                   // A cycle 1
      n_checks++; if (bus.s_wen_o !== 6'h01) begin n_fail++; $display("FAIL b2b_a_s_wen got %h want 01", bus.s_wen_o); end
      step();                                                  // A cycle 2
      bus.s_ack_i = 6'h01;
      step(); bus.s_ack_i = 6'h00;                             // A cycle 3 = B cycle 0
      n_checks++; if (bus.m_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ack got %b want 1", bus.m_ack_o); end
      bus.m_addr_i = 32'h4030_0020; bus.m_ren_i = 1'b1;
      step(); master_idle();                                   // B cycle 1
      n_checks++; if ({bus.m_ack_o, bus.s_ren_o} !== {1'b0, 6'h08}) begin n_fail++; $display("FAIL b2b_b_strobe got %h want 08", {bus.m_ack_o, bus.s_ren_o}); end
      n_checks++; if (bus.s_addr_o !== 32'h4030_0020) begin n_fail++; $display("FAIL b2b_b_s_addr got %h want 40300020", bus.s_addr_o); end
      step();                                                  // B cycle 2
      bus.s_ack_i = 6'h08;
      step(); bus.s_ack_i = 6'h00;                             // B cycle 3
      n_checks++; if ({bus.m_ack_o, bus.m_rdata_o} !== {1'b1, 32'hA5A5_5A5A}) begin n_fail++; $display("FAIL b2b_b_resp got %h want 1a5a55a5a", {bus.m_ack_o, bus.m_rdata_o}); end
      step();
      n_checks++; if ({bus.m_ack_o, bus.m_rdata_o} !== {1'b0, 32'hA5A5_5A5A}) begin n_fail++; $display("FAIL b2b_hold got %h want 0a5a55a5a", {bus.m_ack_o, bus.m_rdata_o}); end
      $display("test_back_to_back done");
   endtask

   initial begin
      bus.m_addr_i  = '0;
      bus.m_wdata_i = '0;
      bus.m_sel_i   = '0;
      bus.m_wen_i   = 1'b0;
      bus.m_ren_i   = 1'b0;
      bus.s_rdata_i = '0;
      bus.s_err_i   = '0;
      bus.s_ack_i   = '0;

      test_reset();
      test_write_idx0();
      test_read_idx3();
      test_decode_error();
      test_timeout();
      test_err_concurrent_drop();
      test_reset_mid();
      test_back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
